// File: rtl/uba_intr_arb.sv
// uba_intr_arb: maps NUM_BR bus requests onto 7 PI lines and runs the WRU grant handshake.
// Define UBA_INTR_SYNC_EN to pass devINTR through a 2-flop synchronizer first.
module uba_intr_arb #(
    parameter int NUM_BR  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          busPI,
    input  logic                wruREAD,
    input  logic [3*NUM_BR-1:0] statPI,
    input  logic [NUM_BR-1:0]   devINTR,
    output logic [6:0]          busINTR,
    output logic [NUM_BR-1:0]   statINT,
    output logic [NUM_BR-1:0]   devINTA,
    output logic                wruACK,
    output logic                wruNONE,
    output logic                intTMO
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GRANT, NONE, RELEASE} state_t;
    state_t state, nxt;
    logic [NUM_BR-1:0] dev, req, cand, win, gnt;
    logic [6:0] pi_req;
    logic [TW-1:0] timer;
    logic wru_q, start, drop, tmo;
`ifdef UBA_INTR_SYNC_EN
    logic [NUM_BR-1:0] sync1, sync2;
    always_ff @(posedge clk or posedge rst)
        if (rst) {sync2, sync1} <= '0;
        else {sync2, sync1} <= {sync1, devINTR};
    assign dev = sync2;
`else
    assign dev = devINTR;
`endif
    always_comb begin
        req = '0;
        cand = '0;
        pi_req = '0;
        win = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            req[i] = dev[i] & (statPI[3*i +: 3] != 3'd0);
            cand[i] = req[i] & (statPI[3*i +: 3] == busPI);
            pi_req |= 7'(req[i]) << (statPI[3*i +: 3] - 3'd1);
        end
        // later (higher) indices overwrite, so the top candidate wins
        for (int i = 0; i < NUM_BR; i++)
            if (cand[i]) win = NUM_BR'(1) << i;
    end
    assign start = wruREAD & ~wru_q;
    assign drop = ~|(dev & gnt);
    assign tmo = timer == TW'(TIMEOUT - 1);
    assign wruACK = state == GRANT;
    assign wruNONE = state == NONE;
    assign intTMO = wruACK & ~drop & tmo;
    assign devINTA = wruACK ? gnt : '0;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = |cand ? GRANT : NONE;
            GRANT:   if (drop | tmo) nxt = RELEASE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            wru_q <= 1'b0;
            timer <= '0;
            gnt <= '0;
            busINTR <= '0;
            statINT <= '0;
        end else begin
            state <= nxt;
            wru_q <= wruREAD;
            busINTR <= pi_req;
            statINT <= dev;
            gnt <= state == IDLE && start ? win : gnt;
            timer <= state != GRANT ? '0 : timer + TW'(timer != '1);
        end
endmodule
